bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter P_RR_INIT, default 1'b0, round-robin "last granted" pointer value at reset (0 = instruction last, so data wins the first tie).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port rst  input  1  asynchronous active-low reset (negedge rst).
REQ-004 SHALL have port bInsIf  BusItf.Slave  32-bit addr/data  instruction-cache requester.
REQ-005 SHALL have port bDataIf  BusItf.Slave  32-bit addr/data  data-cache requester.
REQ-006 SHALL have port bMemIf  BusItf.Master  32-bit addr/data  shared memory bus.
REQ-007 SHALL use BusItf signals valid, ready, wr, addr, dataM2S, dataS2M; types from BusPkg.

Function
REQ-008 SHALL implement FSM states S_IDLE, S_GNT_INS, S_GNT_DATA, S_RESP_INS, S_RESP_DATA.
REQ-009 In S_IDLE: no requests -> stay; only one requester valid -> go to its S_GNT_x next cycle.
REQ-010 Both valid in S_IDLE: grant the requester not equal to the round-robin pointer.
REQ-011 Pointer SHALL update to the granted requester on entry to S_GNT_x.
REQ-012 In S_GNT_x: bMemIf.valid=1 held every cycle until bMemIf.ready; bMemIf.addr/wr/dataM2S combinationally muxed from owner.
REQ-013 In S_GNT_x: owner.ready = bMemIf.ready (same cycle, combinational); then next state S_RESP_x.
REQ-014 In S_RESP_x: owner.dataS2M = bMemIf.dataS2M (read data valid cycle after ready); bMemIf.valid=0.
REQ-015 S_RESP_x SHALL arbitrate exactly as S_IDLE for the next state (back-to-back grants, one idle-valid cycle minimum between transactions).
REQ-016 Non-owner ready=0 and dataS2M=32'h0 in every state; owner dataS2M=0 outside S_RESP_x.
REQ-017 Outside S_GNT_x: bMemIf.valid=0, wr=0, addr=32'h0, dataM2S=32'h0.
REQ-018 Grant latency: request sampled in S_IDLE -> bMemIf.valid asserted exactly one cycle later.
REQ-019 Requesters SHALL hold valid/addr/wr/dataM2S stable until their ready; a requester dropping valid while granted SHALL NOT abort the memory transaction (grant held until bMemIf.ready).
REQ-020 A request arriving while the other requester is granted SHALL wait with ready=0, no loss, and be granted from S_RESP_x.
REQ-021 bMemIf.ready seen outside S_GNT_x SHALL be ignored.
REQ-022 No starvation: with both requesting continuously, grants SHALL strictly alternate.

Reset
REQ-023 rst low SHALL asynchronously force state S_IDLE, pointer P_RR_INIT, all outputs to zero (valid, ready, wr, addr, data).
REQ-024 Reset mid-transaction SHALL drop bMemIf.valid immediately; no ready issued to either requester for the aborted transfer.
REQ-025 After rst deasserts, first arbitration SHALL occur on the first posedge.

Configuration
REQ-026 Macro BUS_ARB_FIXED_PRIO_EN defined: round-robin pointer removed, data requester always wins ties (REQ-010, REQ-022 do not apply; instruction may starve).
REQ-027 Macro undefined: round-robin as in REQ-010/011/022.

Verification
REQ-028 Data-only read addr 32'h0000_0400, memory ready after 3 cycles with 32'h1234_5678 -> bMemIf.valid 1 cycle after request, bDataIf.ready pulse with bMemIf.ready, bDataIf.dataS2M=32'h1234_5678 next cycle.
REQ-029 Both valid same cycle after reset (P_RR_INIT=0) -> data granted first, instruction next; with continuous requests grants alternate D,I,D,I over 8 transactions.
REQ-030 Instruction granted, data write addr 32'h0000_0010 data 32'hCAFE_F00D arrives mid-transfer -> data stalls ready=0, granted from S_RESP_INS, memory sees wr=1 and exact addr/data.
REQ-031 rst pulsed while S_GNT_DATA with memory not ready -> bMemIf.valid=0 same cycle, no bDataIf.ready, state S_IDLE.
REQ-032 Spurious bMemIf.ready=1 in S_IDLE -> both requester ready remain 0.
REQ-033 BUS_ARB_FIXED_PRIO_EN defined, both requesting continuously for 6 transactions -> all 6 grants to data, instruction ready stays 0.

Source files
------------

// File: rtl/bus_arbiter_if.sv
// Shared bus types and the valid/ready request bus used by bus_arbiter.
// Master drives the request side; Slave returns ready and read data.
package BusPkg;
  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;
endpackage

interface BusItf;
  import BusPkg::*;

  logic  valid;
  logic  ready;
  logic  wr;
  addr_t addr;
  data_t dataM2S;
  data_t dataS2M;

  modport Master (output valid, wr, addr, dataM2S, input ready, dataS2M);
  modport Slave  (input valid, wr, addr, dataM2S, output ready, dataS2M);
endinterface

// File: rtl/bus_arbiter.sv
// Two-requester (instruction/data) arbiter onto one memory bus, round-robin on ties.
// Define BUS_ARB_FIXED_PRIO_EN to drop the pointer and always favour the data requester.
module bus_arbiter
  import BusPkg::*;
#(
  parameter logic P_RR_INIT = 1'b0
) (
  input  logic  clk,
  input  logic  rst,
  BusItf.Slave  bInsIf,
  BusItf.Slave  bDataIf,
  BusItf.Master bMemIf
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GNT_INS,
    S_GNT_DATA,
    S_RESP_INS,
    S_RESP_DATA
  } state_e;

  state_e state_q;
  state_e arb_state;
  logic   arb_en;
  logic   data_wins_tie;

  // Pointer holds the last granted requester: 1 = data, 0 = instruction.
`ifdef BUS_ARB_FIXED_PRIO_EN
  assign data_wins_tie = 1'b1;
`else
  logic ptr_q;

  assign data_wins_tie = ~ptr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= P_RR_INIT;
    end else if (arb_en && (arb_state == S_GNT_DATA)) begin
      ptr_q <= 1'b1;
    end else if (arb_en && (arb_state == S_GNT_INS)) begin
      ptr_q <= 1'b0;
    end
  end
`endif

  // Idle and response cycles are the only points where a new owner is chosen.
  assign arb_en = (state_q == S_IDLE) || (state_q == S_RESP_INS) || (state_q == S_RESP_DATA);

  always_comb begin
    arb_state = S_IDLE;
    if (bInsIf.valid && bDataIf.valid) begin
      arb_state = data_wins_tie ? S_GNT_DATA : S_GNT_INS;
    end else if (bDataIf.valid) begin
      arb_state = S_GNT_DATA;
    end else if (bInsIf.valid) begin
      arb_state = S_GNT_INS;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE, S_RESP_INS, S_RESP_DATA: state_q <= arb_state;
        S_GNT_INS:  if (bMemIf.ready) state_q <= S_RESP_INS;
        S_GNT_DATA: if (bMemIf.ready) state_q <= S_RESP_DATA;
        default:    state_q <= S_IDLE;
      endcase
    end
  end

  // Outputs decode from the registered state so reset clears them asynchronously.
  always_comb begin
    bMemIf.valid     = 1'b0;
    bMemIf.wr        = 1'b0;
    bMemIf.addr      = '0;
    bMemIf.dataM2S   = '0;
    bInsIf.ready     = 1'b0;
    bInsIf.dataS2M   = '0;
    bDataIf.ready    = 1'b0;
    bDataIf.dataS2M  = '0;
    unique case (state_q)
      S_GNT_INS: begin
        bMemIf.valid   = 1'b1;
        bMemIf.wr      = bInsIf.wr;
        bMemIf.addr    = bInsIf.addr;
        bMemIf.dataM2S = bInsIf.dataM2S;
        bInsIf.ready   = bMemIf.ready;
      end
      S_GNT_DATA: begin
        bMemIf.valid   = 1'b1;
        bMemIf.wr      = bDataIf.wr;
        bMemIf.addr    = bDataIf.addr;
        bMemIf.dataM2S = bDataIf.dataM2S;
        bDataIf.ready  = bMemIf.ready;
      end
      S_RESP_INS:  bInsIf.dataS2M  = bMemIf.dataS2M;
      S_RESP_DATA: bDataIf.dataS2M = bMemIf.dataS2M;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboarded bench for bus_arbiter: directed requester traffic against a
// latency-configurable memory model; a negedge monitor pops expected grants.
module tb_bus_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  BusItf ins_if ();
  BusItf data_if ();
  BusItf mem_if ();

  bus_arbiter #(
    .P_RR_INIT(1'b0)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bInsIf (ins_if),
    .bDataIf(data_if),
    .bMemIf (mem_if)
  );

  typedef struct packed {
    logic        who;   // 1 = data requester
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        pend_e;
  logic        pend = 1'b0;
  int          total = 0;
  int          bad = 0;
  int          mem_lat = 1;
  int          mem_cnt = 0;
  logic        spurious = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  task automatic check(input string name, input logic [95:0] got, input logic [95:0] need);
    total++;
    if (got !== need) begin
      bad++;
      $display("FAIL %s: got %h need %h", name, got, need);
    end
  endtask

  task automatic push(input logic who, input logic wr, input logic [31:0] a,
                      input logic [31:0] d, input logic [31:0] r);
    exp_q.push_back({who, wr, a, d, r});
  endtask

  task automatic drive(input logic who, input logic v, input logic wr, input logic [31:0] a,
                       input logic [31:0] d);
    if (who) begin
      data_if.valid = v; data_if.wr = wr; data_if.addr = a; data_if.dataM2S = d;
    end else begin
      ins_if.valid = v; ins_if.wr = wr; ins_if.addr = a; ins_if.dataM2S = d;
    end
  endtask

  task automatic wait_ready(input logic who);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = who ? data_if.ready : ins_if.ready;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: requester %0d got no ready, need ready within 200 cycles", who);
    end
  endtask

  task automatic xfer(input logic who, input logic wr, input logic [31:0] a,
                      input logic [31:0] d, input logic keep);
    drive(who, 1'b1, wr, a, d);
    wait_ready(who);
    @(posedge clk); #1;
    if (!keep) drive(who, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("rst_ctl", 96'({mem_if.valid, mem_if.wr, ins_if.ready, data_if.ready}), 96'(0));
    check("rst_addr", 96'(mem_if.addr), 96'(0));
    check("rst_wdata", 96'(mem_if.dataM2S), 96'(0));
    check("rst_rdata", 96'({ins_if.dataS2M, data_if.dataS2M}), 96'(0));
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  // Memory model: ready after mem_lat cycles of valid; spurious forces ready.
  initial begin
    mem_if.ready   = 1'b0;
    mem_if.dataS2M = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (!rst) begin
        mem_cnt = 0;
        mem_if.ready = 1'b0;
      end else if (mem_if.valid) begin
        mem_cnt++;
        if (mem_cnt >= mem_lat) begin
          mem_if.ready = 1'b1;
          mem_cnt = 0;
        end else begin
          mem_if.ready = spurious;
        end
      end else begin
        mem_cnt = 0;
        mem_if.ready = spurious;
      end
      mem_if.dataS2M = mem_rdata;
    end
  end

  // Monitor: pops the scoreboard on every memory handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          check("rdata_owner", 96'(pend_e.who ? data_if.dataS2M : ins_if.dataS2M),
                96'(pend_e.rdata));
          check("rdata_other", 96'(pend_e.who ? ins_if.dataS2M : data_if.dataS2M), 96'(0));
          pend = 1'b0;
        end else begin
          check("s2m_zero", 96'({ins_if.dataS2M, data_if.dataS2M}), 96'(0));
        end
        if (mem_if.valid && mem_if.ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_empty: got handshake addr %h, need no handshake", mem_if.addr);
          end else begin
            pend_e = exp_q.pop_front();
            check("gnt_owner", 96'({data_if.ready, ins_if.ready}),
                  96'({pend_e.who, ~pend_e.who}));
            check("gnt_wr", 96'(mem_if.wr), 96'(pend_e.wr));
            check("gnt_addr", 96'(mem_if.addr), 96'(pend_e.addr));
            check("gnt_wdata", 96'(mem_if.dataM2S), 96'(pend_e.wdata));
            pend = 1'b1;
          end
        end else begin
          check("no_ready", 96'({data_if.ready, ins_if.ready}), 96'(0));
        end
        if (!mem_if.valid) begin
          check("bus_idle_zero", 96'({mem_if.wr, mem_if.addr, mem_if.dataM2S}), 96'(0));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, need finish before 100000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    do_reset();

    // Data-only read, memory ready in the third grant cycle.
    mem_lat = 3;
    mem_rdata = 32'h1234_5678;
    push(1'b1, 1'b0, 32'h0000_0400, 32'h0, 32'h1234_5678);
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0400, 32'h0);
    @(negedge clk);
    check("lat_pre", 96'(mem_if.valid), 96'(0));
    @(negedge clk);
    check("lat_valid", 96'(mem_if.valid), 96'(1));
    check("lat_addr", 96'(mem_if.addr), 96'(32'h0000_0400));
    wait_ready(1'b1);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;

    // Spurious memory ready while idle must not reach either requester.
    spurious = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("spur_no_ready", 96'({data_if.ready, ins_if.ready}), 96'(0));
    end
    spurious = 1'b0;
    repeat (2) @(posedge clk);

    // Continuous requests from both sides straight after reset.
    do_reset();
    mem_lat = 1;
    mem_rdata = 32'h5A5A_A5A5;
`ifdef BUS_ARB_FIXED_PRIO_EN
    for (int n = 0; n < 6; n++) push(1'b1, 1'b0, 32'h1000 + 32'(n * 4), 32'h0, 32'h5A5A_A5A5);
    push(1'b0, 1'b0, 32'h2000, 32'h0, 32'h5A5A_A5A5);
    fork
      begin
        for (int n = 0; n < 6; n++) xfer(1'b1, 1'b0, 32'h1000 + 32'(n * 4), 32'h0, n < 5);
      end
      begin
        xfer(1'b0, 1'b0, 32'h2000, 32'h0, 1'b0);
      end
    join
`else
    for (int n = 0; n < 4; n++) begin
      push(1'b1, 1'b0, 32'h1000 + 32'(n * 4), 32'h0, 32'h5A5A_A5A5);
      push(1'b0, 1'b0, 32'h2000 + 32'(n * 4), 32'h0, 32'h5A5A_A5A5);
    end
    fork
      begin
        for (int n = 0; n < 4; n++) xfer(1'b1, 1'b0, 32'h1000 + 32'(n * 4), 32'h0, n < 3);
      end
      begin
        for (int n = 0; n < 4; n++) xfer(1'b0, 1'b0, 32'h2000 + 32'(n * 4), 32'h0, n < 3);
      end
    join
`endif
    repeat (2) @(posedge clk);
    #1;

    // Data write arrives while instruction owns a slow transfer.
    mem_lat = 4;
    mem_rdata = 32'h0BAD_BEEF;
    push(1'b0, 1'b0, 32'h0000_0300, 32'h0, 32'h0BAD_BEEF);
    push(1'b1, 1'b1, 32'h0000_0010, 32'hCAFE_F00D, 32'h0BAD_BEEF);
    fork
      xfer(1'b0, 1'b0, 32'h0000_0300, 32'h0, 1'b0);
      begin
        repeat (2) begin
          @(posedge clk); #1;
        end
        drive(1'b1, 1'b1, 1'b1, 32'h0000_0010, 32'hCAFE_F00D);
        @(negedge clk);
        check("stall_ready", 96'(data_if.ready), 96'(0));
        check("stall_owner_addr", 96'(mem_if.addr), 96'(32'h0000_0300));
        wait_ready(1'b1);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      end
    join
    repeat (2) @(posedge clk);
    #1;

    // Reset while data is granted and memory is stalled.
    mem_lat = 100;
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0080, 32'h0);
    @(negedge clk);
    @(negedge clk);
    check("abort_pre_valid", 96'(mem_if.valid), 96'(1));
    #2;
    rst = 1'b0;
    #1;
    check("abort_valid_drop", 96'(mem_if.valid), 96'(0));
    check("abort_no_ready", 96'({data_if.ready, ins_if.ready}), 96'(0));
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("abort_hold", 96'(mem_if.valid), 96'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_idle", 96'(mem_if.valid), 96'(0));
    @(posedge clk); #1;
    mem_lat = 1;
    mem_rdata = 32'h0000_00A5;
    push(1'b1, 1'b0, 32'h0000_0044, 32'h0, 32'h0000_00A5);
    drive(1'b1, 1'b1, 1'b0, 32'h0000_0044, 32'h0);
    @(negedge clk);
    check("post_rst_pre", 96'(mem_if.valid), 96'(0));
    @(negedge clk);
    check("post_rst_gnt", 96'(mem_if.valid), 96'(1));
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

    repeat (3) @(negedge clk);
    check("sb_drain", 96'(exp_q.size()), 96'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
